ir_uart_tx_frontend: RTL and testbench

//  Sensor-to-serial front end: conditions the raw IR obstacle input into a clean

---
 rtl/ir_uart_tx_frontend.sv | 161 ++++++++++++++++
 tb/tb_ir_uart_tx_frontend.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ir_uart_tx_frontend.sv
// IR obstacle sensor conditioning (synchronize, polarity-correct, debounce) plus an 8N1 UART
// transmitter. The two paths share only the clock and reset.
//
// state | meaning
// IDLE  | line high, waiting for tx_start
// START | driving the start bit (0)
// DATA  | driving data bits LSB first, bit_q selects which
// STOP  | driving the stop bit (1)
module ir_uart_tx_frontend #(
    parameter int CLK_FREQ          = 12_000_000,
    parameter int BAUD_RATE         = 9600,
    parameter int SENSOR_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYCLES   = 12_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_sensor,
    output logic       obstacle_detected,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    // Raw pin level meaning "no obstacle"; synchronizer resets to it so reset exit is quiet.
    localparam logic SENSOR_IDLE = (SENSOR_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             obst_q, obst_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             sensor_lvl;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              baud_tick;

    assign sensor_lvl = sync2_q ^ SENSOR_IDLE;

    always_comb begin
        sync1_d   = ir_sensor;
        sync2_d   = sync1_q;
        obst_d    = obst_q;
        deb_cnt_d = '0;
        if (sensor_lvl != obst_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                obst_d = sensor_lvl;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= SENSOR_IDLE;
            sync2_q   <= SENSOR_IDLE;
            obst_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            obst_q    <= obst_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign baud_tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign obstacle_detected = obst_q;
    assign tx                = tx_q;
    assign tx_busy           = busy_q;

endmodule

// File: tb/tb_ir_uart_tx_frontend.sv
// Bench for ir_uart_tx_frontend: table-driven frames, directed debounce/reset sequences and a
// randomized run against a window/timeline reference model.
module tb_ir_uart_tx_frontend;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ir_a = 1'b1;
    logic       ir_b = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       start_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       obst_a, tx_a, busy_a;
    logic       obst_b, tx_b, busy_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ir_uart_tx_frontend #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .SENSOR_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .ir_sensor(ir_a), .obstacle_detected(obst_a),
        .tx_start(tx_start), .tx_data(tx_data), .tx(tx_a), .tx_busy(busy_a)
    );

    ir_uart_tx_frontend #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .SENSOR_ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4)
    ) dut_b (
        .clk(clk), .rst(rst), .ir_sensor(ir_b), .obstacle_detected(obst_b),
        .tx_start(start_b), .tx_data(data_b), .tx(tx_b), .tx_busy(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        logic [0:9] bits;   // line levels start..stop, index 0 first
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Called at a negedge; one frame accepted at the next posedge, checked every clock.
    task automatic send_and_check(input logic [7:0] b, input logic [0:9] bits);
        tx_data  = b;
        tx_start = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) tx_start = 1'b0;
            chk("frame_tx", tx_a, bits[k/10]);
            chk("frame_busy", busy_a, 1'b1);
            if (k == 30) tx_data = 8'hFF;
            if (k == 50) tx_start = 1'b1;
            if (k == 51) tx_start = 1'b0;
        end
        @(negedge clk);
        chk("frame_end_busy", busy_a, 1'b0);
        chk("frame_end_tx", tx_a, 1'b1);
    endtask

    // Reference model state for the randomized run
    logic hist[$];
    logic m_obst;
    int   m_acc;
    int   m_cyc;
    logic [7:0] m_byte;
    logic exp_tx, exp_busy;

    initial begin
        vecs[0] = '{8'h31, 10'b0100011001};
        vecs[1] = '{8'h0A, 10'b0010100001};
        vecs[2] = '{8'h00, 10'b0000000001};
        vecs[3] = '{8'hFF, 10'b0111111111};
        vecs[4] = '{8'hA5, 10'b0101001011};

        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_obst", obst_a, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_tx", tx_a, 1'b1);
        chk("idle_busy", busy_a, 1'b0);
        chk("idle_b_tx", tx_b, 1'b1);
        chk("idle_b_busy", busy_b, 1'b0);
        chk("idle_b_obst", obst_b, 1'b0);

        // Active-low sensor: assert, release, then a 3-clock glitch
        ir_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("deb_a_assert", obst_a, k == 6);
        end
        ir_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("deb_a_release", obst_a, k != 6);
        end
        ir_a = 1'b0;
        repeat (3) @(negedge clk);
        ir_a = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("deb_a_glitch", obst_a, 1'b0);
        end

        // Active-high sensor instance
        ir_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("deb_b_assert", obst_b, k == 6);
        end
        ir_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("deb_b_release", obst_b, k != 6);
        end

        // Frames back-to-back, each with mid-frame data change and an ignored start pulse
        for (int i = 0; i < 5; i++) send_and_check(vecs[i].data, vecs[i].bits);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("no_queued_busy", busy_a, 1'b0);
            chk("no_queued_tx", tx_a, 1'b1);
        end

        // tx_start held high: next frame accepted one clock after busy falls, new data captured
        tx_data  = 8'h55;
        tx_start = 1'b1;
        for (int k = 0; k <= 205; k++) begin
            @(negedge clk);
            if (k == 40) tx_data = 8'hF0;
            if (k == 101) tx_start = 1'b0;
            if (k == 99) chk("hold_busy1", busy_a, 1'b1);
            if (k == 100) chk("hold_gap", busy_a, 1'b0);
            if (k == 101) begin
                chk("hold_busy2", busy_a, 1'b1);
                chk("hold_start2", tx_a, 1'b0);
            end
            if (k == 105) chk("hold_start2_mid", tx_a, 1'b0);
            if (k == 115) chk("hold_bit0", tx_a, 1'b0);
            if (k == 165) chk("hold_bit5", tx_a, 1'b1);
            if (k == 200) chk("hold_end_busy", busy_a, 1'b1);
            if (k == 201) chk("hold_done", busy_a, 1'b0);
        end

        // Reset in the middle of a frame with the obstacle flag set
        ir_a = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_obst", obst_a, 1'b1);
        tx_data  = 8'h31;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (35) @(negedge clk);
        chk("pre_rst_busy", busy_a, 1'b1);
        #2;
        rst  = 1'b1;
        ir_a = 1'b1;
        #1;
        chk("midrst_tx", tx_a, 1'b1);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_obst", obst_a, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("post_rst_tx", tx_a, 1'b1);
            chk("post_rst_busy", busy_a, 1'b0);
            chk("post_rst_obst", obst_a, 1'b0);
        end

        // Randomized run against the reference model
        hist   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        m_obst = 1'b0;
        m_acc  = -1000;
        m_cyc  = 0;
        m_byte = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            tx_start = (((i / 400) % 2) == 1) ? 1'b1 : ($urandom_range(0, 24) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 4) == 0) ir_a = ~ir_a;

            // Sensor: flips once the corrected level seen at edges c-5..c-2 all disagree with it
            hist.push_back(ir_a);
            begin
                int n;
                logic lv;
                n  = hist.size();
                lv = !hist[n-3];
                if ((!hist[n-4] == lv) && (!hist[n-5] == lv) && (!hist[n-6] == lv) && (lv != m_obst))
                    m_obst = lv;
                hist.pop_front();
            end
            // UART: frame timeline relative to accept edge
            begin
                int d;
                int idx;
                if (tx_start && (m_cyc - m_acc) >= 101) begin
                    m_acc  = m_cyc;
                    m_byte = tx_data;
                end
                d = m_cyc - m_acc;
                if (d < 100) begin
                    idx      = d / 10;
                    exp_busy = 1'b1;
                    exp_tx   = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : m_byte[idx-1];
                end else begin
                    exp_busy = 1'b0;
                    exp_tx   = 1'b1;
                end
            end
            m_cyc++;

            @(negedge clk);
            chk("rand_tx", tx_a, exp_tx);
            chk("rand_busy", busy_a, exp_busy);
            chk("rand_obst", obst_a, m_obst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
